load_counter_n: RTL and testbench

LOAD_COUNTER_N -- requirements
Module: load_counter_n

---
 rtl/load_counter_pkg.sv | 8 +
 rtl/load_counter_next.sv | 41 ++++
 rtl/load_counter_n.sv | 65 ++++++
 tb/tb_load_counter_n.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/load_counter_pkg.sv
// Shared constants for the loadable modulo-N counter.
// Direction encoding and default geometry.
package load_counter_pkg;
   localparam logic   DIR_UP     = 1'b0;
   localparam logic   DIR_DN     = 1'b1;
   localparam int     DEF_WIDTH  = 4;
   localparam longint DEF_MOD    = 16;
endpackage

// File: rtl/load_counter_next.sv
// Combinational next-count and terminal-count decision.
// Define LOAD_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module load_counter_next
   import load_counter_pkg::*;
#(
   parameter int     WIDTH = DEF_WIDTH,
   parameter longint MOD   = DEF_MOD
) (
   input  logic [WIDTH-1:0] count,
   input  logic             dir,
   output logic [WIDTH-1:0] next,
   output logic             tc
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

   logic at_lim;
   logic [WIDTH-1:0] wrap;

   always_comb begin
      at_lim = 1'b0;
      next   = count;
      wrap   = '0;
      if (dir == DIR_DN) begin
         at_lim = (count == '0);
         wrap   = TOP;
         if (!at_lim) next = count - WIDTH'(1);
      end else begin
         at_lim = (count == TOP);
         wrap   = '0;
         if (!at_lim) next = count + WIDTH'(1);
      end
`ifdef LOAD_COUNTER_SAT_EN
      if (at_lim) next = count;
`else
      if (at_lim) next = wrap;
`endif
      tc = at_lim;
   end

endmodule

// File: rtl/load_counter_n.sv
// Loadable up/down modulo-MOD counter with tc, sticky ovf and lderr flags.
// Saturating variant selected by LOAD_COUNTER_SAT_EN.
module load_counter_n
   import load_counter_pkg::*;
#(
   parameter int     WIDTH = DEF_WIDTH,
   parameter longint MOD   = DEF_MOD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             ovf,
   output logic             lderr
);

   localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] nxt;
   logic             nxt_tc;

   load_counter_next #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) u_next (
      .count (out),
      .dir   (dir),
      .next  (nxt),
      .tc    (nxt_tc)
   );

   // clr > load > en; pulses drop on any edge that does not re-fire them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out   <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
         lderr <= 1'b0;
      end else begin
         tc    <= 1'b0;
         lderr <= 1'b0;
         if (clr) begin
            out <= '0;
            ovf <= 1'b0;
         end else if (load) begin
            if (data > TOP) begin
               out   <= TOP;
               lderr <= 1'b1;
            end else begin
               out <= data;
            end
         end else if (en) begin
            out <= nxt;
            tc  <= nxt_tc;
            if (nxt_tc) ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_load_counter_n.sv
// Self-checking bench: directed scenarios then random traffic
// compared against an arithmetic reference model (WIDTH=4, MOD=10).
module tb_load_counter_n;

   localparam int W   = 4;
   localparam int MOD = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clr = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] data = '0;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic [W-1:0] out;
   logic         tc;
   logic         ovf;
   logic         lderr;

   int checks = 0;
   int errors = 0;

   int m_out = 0;
   int m_tc = 0;
   int m_ovf = 0;
   int m_lderr = 0;

`ifdef LOAD_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   load_counter_n #(
      .WIDTH (W),
      .MOD   (MOD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .load  (load),
      .data  (data),
      .en    (en),
      .dir   (dir),
      .out   (out),
      .tc    (tc),
      .ovf   (ovf),
      .lderr (lderr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"}, int'(out), m_out);
      check({tag, ".tc"}, int'(tc), m_tc);
      check({tag, ".ovf"}, int'(ovf), m_ovf);
      check({tag, ".lderr"}, int'(lderr), m_lderr);
   endtask

   task automatic model_reset();
      m_out = 0;
      m_tc = 0;
      m_ovf = 0;
      m_lderr = 0;
   endtask

   task automatic model_edge(input bit c, input bit l, input int d,
                             input bit e, input bit dn);
      m_tc = 0;
      m_lderr = 0;
      if (c) begin
         m_out = 0;
         m_ovf = 0;
      end else if (l) begin
         if (d >= MOD) begin
            m_out = MOD - 1;
            m_lderr = 1;
         end else begin
            m_out = d;
         end
      end else if (e) begin
         if ((!dn && m_out == MOD - 1) || (dn && m_out == 0)) begin
            m_tc = 1;
            m_ovf = 1;
            if (!SAT) m_out = dn ? MOD - 1 : 0;
         end else begin
            m_out = dn ? m_out - 1 : m_out + 1;
         end
      end
   endtask

   task automatic step(input string tag, input bit c, input bit l,
                       input int d, input bit e, input bit dn);
      clr = c;
      load = l;
      data = W'(d);
      en = e;
      dir = dn;
      @(posedge clk);
      model_edge(c, l, d, e, dn);
      #1;
      check_all(tag);
   endtask

   initial begin
      #3;
      model_reset();
      check_all("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // async reset mid-count at out=5
      step("ld5", 0, 1, 5, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      #1;
      rst_n = 1'b1;

      // up wrap
      step("up_ld8", 0, 1, 8, 0, 0);
      step("up_9", 0, 0, 0, 1, 0);
      step("up_wrap", 0, 0, 0, 1, 0);
      step("up_after", 0, 0, 0, 1, 0);

      // down wrap
      step("dn_clr", 1, 0, 0, 0, 0);
      step("dn_ld1", 0, 1, 1, 0, 1);
      step("dn_0", 0, 0, 0, 1, 1);
      step("dn_wrap", 0, 0, 0, 1, 1);
      step("dn_after", 0, 0, 0, 1, 1);

      // load range
      step("ld12", 0, 1, 12, 0, 0);
      step("ld12_drop", 0, 0, 0, 0, 0);
      step("ld6", 0, 1, 6, 0, 0);
      step("ld15", 0, 1, 15, 1, 0);
      step("ld10", 0, 1, 10, 0, 1);

      // priority at out=7 with ovf set
      step("pr_ld7", 0, 1, 7, 0, 0);
      check("pr_ovf_set", int'(ovf), 1);
      step("pr_clr", 1, 1, 3, 1, 0);
      step("pr_load", 0, 1, 3, 1, 0);

      // hold at 4
      step("hold_ld4", 0, 1, 4, 0, 0);
      for (int i = 0; i < 10; i++) step("hold", 0, 0, 0, 0, i[0]);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step("rnd",
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 5) == 0,
              int'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 49) == 0) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all("rnd_rst");
            rst_n = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
